// File: rtl/qclk_sched.sv
//==============================================================================
// Module      : qclk_sched
// Description : Timestamped event queue that fires each head entry when the
//               qclk counter reaches (or has passed) its timestamp.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module qclk_sched #(
   parameter int WIDTH  = 32,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           qclk_val,
   input  logic [WIDTH-1:0]           in_ts,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       flush,
   output logic                       fire,
   output logic [DATA_W-1:0]          fire_data,
   output logic                       late,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int                 c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]      c_FULL = (c_AW+1)'(DEPTH);
   localparam logic [0:0]         c_WAIT = 1'b0;
   localparam logic [0:0]         c_FIRE = 1'b1;

   logic [WIDTH-1:0]  r_ts   [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [c_AW-1:0]   r_wptr;
   logic [c_AW-1:0]   r_rptr;
   logic [c_AW:0]     r_count;
   logic [0:0]        r_state;
   logic              r_alive;
   logic              r_fire;
   logic              r_late;
   logic [DATA_W-1:0] r_fire_data;

   logic [WIDTH-1:0]  w_diff;
   logic              w_push;
   logic              w_pop;

   // r_alive keeps in_ready low through reset and until the first clock edge
   assign in_ready  = r_alive && (r_count < c_FULL) && !flush;
   assign w_push    = in_valid && in_ready;
   assign w_diff    = r_ts[r_rptr] - qclk_val;
   assign w_pop     = (r_state == c_WAIT) && (r_count != '0) &&
                      ((w_diff == '0) || w_diff[WIDTH-1]);

   assign count     = r_count;
   assign fire      = r_fire;
   assign late      = r_late;
   assign fire_data = r_fire_data;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ts[r_wptr]   <= in_ts;
         r_data[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_state     <= c_WAIT;
         r_alive     <= 1'b0;
         r_fire      <= 1'b0;
         r_late      <= 1'b0;
         r_fire_data <= '0;
      end else begin
         r_alive <= 1'b1;
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= c_WAIT;
            r_fire  <= 1'b0;
            r_late  <= 1'b0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
            case (r_state)
               c_WAIT: begin
                  if (w_pop) begin
                     r_state     <= c_FIRE;
                     r_fire      <= 1'b1;
                     r_fire_data <= r_data[r_rptr];
                     r_late      <= w_diff[WIDTH-1];
                     r_rptr      <= r_rptr + 1'b1;
                  end else begin
                     r_fire <= 1'b0;
                  end
               end
               default: begin
                  // one-cycle cooldown: no compare while the strobe is high
                  r_state <= c_WAIT;
                  r_fire  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_qclk_sched.sv
//==============================================================================
// Module      : tb_qclk_sched
// Description : Scoreboard bench for qclk_sched against a queue-based model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qclk_sched;

   localparam int WIDTH  = 32;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [WIDTH-1:0]  qclk_val = '0;
   logic [WIDTH-1:0]  in_ts = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              flush = 1'b0;
   logic              fire;
   logic [DATA_W-1:0] fire_data;
   logic              late;
   logic [CW-1:0]     count;

   qclk_sched #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .qclk_val  (qclk_val),
      .in_ts     (in_ts),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .fire      (fire),
      .fire_data (fire_data),
      .late      (late),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0]  ts;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              late;
      int unsigned       cyc;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   bit          m_cool  = 1'b0;
   bit          m_alive = 1'b0;
   int unsigned cyc     = 0;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a list of pending events; the head fires once its
   // timestamp is reached or passed, except in the cycle right after a fire.
   always @(posedge clk or negedge rst) begin
      logic [WIDTH-1:0] d;
      bit               acc;
      bit               fired;
      if (!rst) begin
         mq.delete();
         sb.delete();
         m_cool  = 1'b0;
         m_alive = 1'b0;
      end else begin
         cyc++;
         if (flush) begin
            mq.delete();
            m_cool = 1'b0;
         end else begin
            acc   = m_alive && (mq.size() < DEPTH) && in_valid;
            fired = 1'b0;
            if (!m_cool && mq.size() > 0) begin
               d = mq[0].ts - qclk_val;
               if (d == '0 || d[WIDTH-1]) begin
                  sb.push_back('{data: mq[0].data, late: d[WIDTH-1], cyc: cyc});
                  void'(mq.pop_front());
                  fired = 1'b1;
               end
            end
            if (acc) mq.push_back('{ts: in_ts, data: in_data});
            m_cool = fired;
         end
         m_alive = 1'b1;
      end
   end

   // Monitor: compares the DUT against the model just after every edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         chk("count", 64'(count), 64'(mq.size()));
         chk("in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !flush));
         if (fire) begin
            if (sb.size() == 0) begin
               chk("unexpected_fire", 64'(fire), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("fire_cycle", 64'(cyc), 64'(e.cyc));
               chk("fire_data", 64'(fire_data), 64'(e.data));
               chk("late", 64'(late), 64'(e.late));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missed_fire", 64'(fire), 64'd1);
         end
      end
   end

   task automatic step(input bit v, input logic [WIDTH-1:0] ts,
                       input logic [DATA_W-1:0] dat, input bit fl,
                       input logic [WIDTH-1:0] q);
      @(negedge clk);
      in_valid = v;
      in_ts    = ts;
      in_data  = dat;
      flush    = fl;
      qclk_val = q;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, qclk_val + 1);
   endtask

   initial begin
      logic [WIDTH-1:0] q;
      repeat (3) @(negedge clk);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_fire", 64'(fire), 64'd0);
      chk("rst_late", 64'(late), 64'd0);
      chk("rst_fire_data", 64'(fire_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      idle(2);

      // on-time fire at qclk=100
      step(1'b1, 32'd100, 16'hA5, 1'b0, 32'd90);
      idle(16);
      // already-late entry
      step(1'b1, 32'd50, 16'h5A, 1'b0, 32'd60);
      idle(5);
      // fill to DEPTH, keep pushing a 5th, then drain back-to-back fires
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(200 + i), 16'(16'h100 + i), 1'b0, 32'(190 + i));
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'd204, 16'h1FF, 1'b0, 32'(194 + i));
      idle(20);
      // timestamp past the wrap point
      step(1'b1, 32'h0000_0003, 16'hC3, 1'b0, 32'hFFFF_FFFC);
      idle(12);
      // flush with concurrent push
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(2000 + i), 16'(16'h200 + i), 1'b0, 32'(1000 + i));
      step(1'b1, 32'd1004, 16'h2FF, 1'b1, 32'd1003);
      idle(8);

      // randomized traffic with occasional qclk jumps and flushes
      for (int i = 0; i < 600; i++) begin
         q = qclk_val + 1;
         if ($urandom_range(0, 24) == 0) q = $urandom();
         if (i == 300) q = 32'hFFFF_FFF6;
         step(1'($urandom_range(0, 1)),
              q + 32'($urandom_range(0, 16)) - 32'd4,
              16'($urandom()),
              ($urandom_range(0, 39) == 0),
              q);
      end
      idle(25);

      // asynchronous reset mid-cycle with two entries queued
      step(1'b1, qclk_val + 32'd50, 16'hD1, 1'b0, qclk_val + 1);
      step(1'b1, qclk_val + 32'd50, 16'hD2, 1'b0, qclk_val + 1);
      step(1'b0, '0, '0, 1'b0, qclk_val + 1);
      @(posedge clk);
      chk("pre_rst_count", 64'(count), 64'd2);
      #3 rst = 1'b0;
      #1;
      chk("async_count", 64'(count), 64'd0);
      chk("async_fire", 64'(fire), 64'd0);
      chk("async_late", 64'(late), 64'd0);
      chk("async_fire_data", 64'(fire_data), 64'd0);
      chk("async_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_count", 64'(count), 64'd0);
      idle(70);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
